// File: rtl/mips_pkg.sv
// Shared constants and loader state encoding for the mips external memory.
// No logic; no latency.
// No flow control.
package mips_pkg;

    localparam int WIDTH  = 8;
    localparam int AWIDTH = 8;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } ld_state_t;

endpackage

// File: rtl/mips_ram256.sv
// DEPTH x WIDTH byte store with one synchronous write port and one asynchronous read port.
// Write lands at the rising edge; read is combinational (zero cycles).
// No backpressure; a write is accepted every cycle it is enabled.
module mips_ram256 #(
    parameter int WIDTH  = 8,
    parameter int AWIDTH = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_adr,
    input  logic [WIDTH-1:0]  wr_dat,
    input  logic [AWIDTH-1:0] rd_adr,
    output logic [WIDTH-1:0]  rd_dat
);

    localparam int DEPTH = 1 << AWIDTH;

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents deliberately survive reset so a partial image can be inspected or overwritten.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_adr] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_adr];

endmodule

// File: rtl/mips_exmem_loader.sv
// Byte RAM for the multicycle mips core with a streaming program loader in front of it.
// Loader bytes and core stores commit at the rising edge; core reads are combinational.
// load_ready drops outside LOAD; the core is held in reset until a complete image is accepted.
module mips_exmem_loader #(
    parameter int WIDTH  = mips_pkg::WIDTH,
    parameter int AWIDTH = mips_pkg::AWIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AWIDTH-1:0] adr,
    input  logic              memread,
    input  logic              memwrite,
    input  logic [WIDTH-1:0]  writedata,
    output logic [WIDTH-1:0]  memdata,
    input  logic              load_valid,
    input  logic [WIDTH-1:0]  load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              core_reset,
    output logic [AWIDTH:0]   load_count,
    output logic              load_err
);

    import mips_pkg::*;

    localparam logic [AWIDTH-1:0] PTR_LAST = '1;
    localparam logic [AWIDTH:0]   CNT_MAX  = {1'b1, {AWIDTH{1'b0}}};

    ld_state_t         state;
    ld_state_t         state_nxt;
    logic [AWIDTH-1:0] ptr;
    logic              xfer;

    logic              wr_en;
    logic [AWIDTH-1:0] wr_adr;
    logic [WIDTH-1:0]  wr_dat;
    logic [WIDTH-1:0]  rd_dat;

    // The core's read strobe is advisory: data is driven on every cycle regardless.
    logic unused_memread;
    assign unused_memread = memread;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_LOAD;
            ptr        <= '0;
            load_count <= '0;
        end else begin
            state <= state_nxt;
            if (xfer) begin
                // The final slot ends the load, so ptr is never allowed to wrap back to 0.
                if (ptr != PTR_LAST) begin
                    ptr <= ptr + 1'b1;
                end
                if (load_count != CNT_MAX) begin
                    load_count <= load_count + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        xfer       = 1'b0;
        load_ready = 1'b0;
        core_reset = 1'b1;
        load_err   = 1'b0;
        wr_en      = 1'b0;
        wr_adr     = ptr;
        wr_dat     = load_data;
        memdata    = '0;

        case (state)
            ST_LOAD: begin
                load_ready = 1'b1;
                xfer       = load_valid;
                wr_en      = load_valid;
                if (load_valid) begin
                    if (load_last) begin
                        state_nxt = ST_RUN;
                    end else if (ptr == PTR_LAST) begin
                        state_nxt = ST_ERR;
                    end
                end
            end
            ST_RUN: begin
                core_reset = 1'b0;
                wr_en      = memwrite;
                wr_adr     = adr;
                wr_dat     = writedata;
                memdata    = rd_dat;
            end
            ST_ERR: begin
                load_err = 1'b1;
            end
            default: begin
                state_nxt = ST_ERR;
            end
        endcase
    end

    mips_ram256 #(
        .WIDTH  (WIDTH),
        .AWIDTH (AWIDTH)
    ) u_ram (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_adr (wr_adr),
        .wr_dat (wr_dat),
        .rd_adr (adr),
        .rd_dat (rd_dat)
    );

endmodule

// File: tb/tb_mips_exmem_loader.sv
// Directed vector bench for mips_exmem_loader: cycle table plus full-depth load sequences.
module tb_mips_exmem_loader;

    logic       clk;
    logic       reset;
    logic [7:0] adr;
    logic       memread;
    logic       memwrite;
    logic [7:0] writedata;
    logic [7:0] memdata;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_last;
    logic       load_ready;
    logic       core_reset;
    logic [8:0] load_count;
    logic       load_err;

    int passed = 0;
    int total  = 0;

    mips_exmem_loader dut (
        .clk        (clk),
        .reset      (reset),
        .adr        (adr),
        .memread    (memread),
        .memwrite   (memwrite),
        .writedata  (writedata),
        .memdata    (memdata),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .core_reset (core_reset),
        .load_count (load_count),
        .load_err   (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       lv;
        logic [7:0] ld;
        logic       ll;
        logic       mw;
        logic [7:0] a;
        logic [7:0] wd;
        logic [7:0] e_md;
        logic       e_cr;
        logic       e_rdy;
        logic       e_err;
        logic [8:0] e_cnt;
    } vec_t;

    vec_t tab[$];

    function automatic vec_t mk(input logic rst, input logic lv, input logic [7:0] ld,
                                input logic ll, input logic mw, input logic [7:0] a,
                                input logic [7:0] wd, input logic [7:0] e_md,
                                input logic e_cr, input logic e_rdy, input logic e_err,
                                input logic [8:0] e_cnt);
        vec_t v;
        v.rst = rst; v.lv = lv; v.ld = ld; v.ll = ll; v.mw = mw; v.a = a; v.wd = wd;
        v.e_md = e_md; v.e_cr = e_cr; v.e_rdy = e_rdy; v.e_err = e_err; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
    endtask

    task automatic drive(input logic rst, input logic lv, input logic [7:0] ld,
                         input logic ll, input logic mw, input logic [7:0] a,
                         input logic [7:0] wd);
        @(negedge clk);
        reset = rst; load_valid = lv; load_data = ld; load_last = ll;
        memwrite = mw; adr = a; writedata = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input int idx, input logic [7:0] e_md, input logic e_cr,
                           input logic e_rdy, input logic e_err, input logic [8:0] e_cnt);
        chk("memdata",    idx, 32'(memdata),    32'(e_md));
        chk("core_reset", idx, 32'(core_reset), 32'(e_cr));
        chk("load_ready", idx, 32'(load_ready), 32'(e_rdy));
        chk("load_err",   idx, 32'(load_err),   32'(e_err));
        chk("load_count", idx, 32'(load_count), 32'(e_cnt));
    endtask

    initial begin
        reset = 1'b1; adr = '0; memread = 1'b1; memwrite = 1'b0; writedata = '0;
        load_valid = 1'b0; load_data = '0; load_last = 1'b0;

        // Basic load 44,00,02,80 then run-phase reads and a store.
        tab.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 0, 9'd0));
        tab.push_back(mk(0, 1, 8'h44, 0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 0, 9'd1));
        tab.push_back(mk(0, 1, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 0, 9'd2));
        tab.push_back(mk(0, 1, 8'h02, 0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 0, 9'd3));
        tab.push_back(mk(0, 1, 8'h80, 1, 0, 8'h00, 8'h00, 8'h44, 0, 0, 0, 9'd4));
        tab.push_back(mk(0, 0, 8'h00, 0, 0, 8'h01, 8'h00, 8'h00, 0, 0, 0, 9'd4));
        tab.push_back(mk(0, 0, 8'h00, 0, 0, 8'h02, 8'h00, 8'h02, 0, 0, 0, 9'd4));
        tab.push_back(mk(0, 0, 8'h00, 0, 0, 8'h03, 8'h00, 8'h80, 0, 0, 0, 9'd4));
        tab.push_back(mk(0, 0, 8'h00, 0, 1, 8'h10, 8'hA0, 8'hA0, 0, 0, 0, 9'd4));
        tab.push_back(mk(0, 1, 8'h99, 1, 0, 8'h00, 8'h00, 8'h44, 0, 0, 0, 9'd4));
        tab.push_back(mk(0, 0, 8'h00, 0, 0, 8'h10, 8'h00, 8'hA0, 0, 0, 0, 9'd4));
        // Gapped loader valid.
        tab.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 0, 9'd0));
        tab.push_back(mk(0, 1, 8'h05, 0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 0, 9'd1));
        for (int i = 0; i < 3; i++)
            tab.push_back(mk(0, 0, 8'hEE, 1, 0, 8'h00, 8'h00, 8'h00, 1, 1, 0, 9'd1));
        tab.push_back(mk(0, 1, 8'h06, 0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 0, 9'd2));
        tab.push_back(mk(0, 0, 8'hEE, 1, 0, 8'h00, 8'h00, 8'h00, 1, 1, 0, 9'd2));
        tab.push_back(mk(0, 1, 8'h07, 1, 0, 8'h00, 8'h00, 8'h05, 0, 0, 0, 9'd3));
        tab.push_back(mk(0, 0, 8'h00, 0, 0, 8'h01, 8'h00, 8'h06, 0, 0, 0, 9'd3));
        tab.push_back(mk(0, 0, 8'h00, 0, 0, 8'h02, 8'h00, 8'h07, 0, 0, 0, 9'd3));
        // Reload after a mid-load reset; core stores during LOAD must not land.
        tab.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 0, 9'd0));
        tab.push_back(mk(0, 1, 8'h01, 0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 0, 9'd1));
        tab.push_back(mk(0, 1, 8'h02, 0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 0, 9'd2));
        tab.push_back(mk(0, 1, 8'h03, 0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 0, 9'd3));
        tab.push_back(mk(0, 1, 8'hD4, 1, 0, 8'h03, 8'h00, 8'hD4, 0, 0, 0, 9'd4));
        tab.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 0, 9'd0));
        tab.push_back(mk(0, 1, 8'hE1, 0, 1, 8'h03, 8'hFF, 8'h00, 1, 1, 0, 9'd1));
        tab.push_back(mk(0, 1, 8'hE2, 0, 1, 8'h03, 8'hFF, 8'h00, 1, 1, 0, 9'd2));
        tab.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 0, 9'd0));
        tab.push_back(mk(0, 1, 8'h11, 0, 1, 8'h03, 8'hEE, 8'h00, 1, 1, 0, 9'd1));
        tab.push_back(mk(0, 1, 8'h22, 0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 0, 9'd2));
        tab.push_back(mk(0, 1, 8'h33, 1, 0, 8'h00, 8'h00, 8'h11, 0, 0, 0, 9'd3));
        tab.push_back(mk(0, 0, 8'h00, 0, 0, 8'h01, 8'h00, 8'h22, 0, 0, 0, 9'd3));
        tab.push_back(mk(0, 0, 8'h00, 0, 0, 8'h02, 8'h00, 8'h33, 0, 0, 0, 9'd3));
        tab.push_back(mk(0, 0, 8'h00, 0, 0, 8'h03, 8'h00, 8'hD4, 0, 0, 0, 9'd3));

        foreach (tab[i]) begin
            drive(tab[i].rst, tab[i].lv, tab[i].ld, tab[i].ll, tab[i].mw, tab[i].a, tab[i].wd);
            chk_all(i, tab[i].e_md, tab[i].e_cr, tab[i].e_rdy, tab[i].e_err, tab[i].e_cnt);
        end

        // Overflow: 256 bytes without last.
        drive(1, 0, 8'h00, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 255; i++)
            drive(0, 1, 8'(i) ^ 8'h5A, 0, 0, 8'h00, 8'h00);
        chk_all(1000, 8'h00, 1, 1, 0, 9'd255);
        drive(0, 1, 8'hA5, 0, 0, 8'h00, 8'h00);
        chk_all(1001, 8'h00, 1, 0, 1, 9'd256);
        drive(0, 1, 8'h12, 1, 1, 8'h00, 8'h34);
        chk_all(1002, 8'h00, 1, 0, 1, 9'd256);
        drive(1, 0, 8'h00, 0, 0, 8'h00, 8'h00);
        chk_all(1003, 8'h00, 1, 1, 0, 9'd0);

        // Full 256-byte image terminated exactly on the last slot.
        for (int i = 0; i < 255; i++)
            drive(0, 1, 8'(i) ^ 8'h5A, 0, 0, 8'h00, 8'h00);
        drive(0, 1, 8'hA5, 1, 0, 8'hFF, 8'h00);
        chk_all(1004, 8'hA5, 0, 0, 0, 9'd256);
        drive(0, 0, 8'h00, 0, 0, 8'h00, 8'h00);
        chk_all(1005, 8'h5A, 0, 0, 0, 9'd256);

        // Same-cycle read/write: old byte before the edge, new byte after.
        @(negedge clk);
        adr = 8'h20; memwrite = 1'b1; writedata = 8'h77;
        #1;
        chk("rw_old", 1006, 32'(memdata), 32'(8'h20 ^ 8'h5A));
        @(posedge clk);
        #1;
        chk("rw_new", 1007, 32'(memdata), 32'h77);
        @(negedge clk);
        memwrite = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
